dmem_arbiter: RTL and testbench

- Shares the single-port data memory (32-bit data_out/data_in/address, MemRead/MemWrite, Clk) between two requesters.
  - Port 0: CPU MEM stage.
  - Port 1: debug/loader port.
- Accepts one request at a time, sequences the memory control strobes, captures read data and returns a one-cycle ack.
- Round-robin arbitration by default; sits between the pipeline MEM stage and the DataMemory instance.

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_rr_pick.sv | 22 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the two-port data-memory arbiter: FSM state encoding and port ids.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way picker: a lone requester wins, a tie goes to the port that was not served last.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_valid_c,
  output logic o_winner_c
);

  always_comb begin
    o_valid_c  = i_req0 | i_req1;
    o_winner_c = PORT0;
    if (i_req0 && i_req1) begin
      o_winner_c = ~i_rr_last;
    end else if (i_req1) begin
      o_winner_c = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (CPU MEM stage + debug/loader port).
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_in_resp;
  logic              w_req0_m;
  logic              w_req1_m;
  logic              w_rr_last;
  logic              w_pick_valid;
  logic              w_pick_id;
  logic              w_load;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_in_resp = (r_state == ST_RESP);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Port 0 keeps priority: a still-pending port 0 blocks port 1 from stealing the RESP slot.
  assign w_rr_last = PORT1;
  assign w_req0_m  = req0 & ~(w_in_resp & (r_grant == PORT0));
  assign w_req1_m  = req1 & ~(w_in_resp & (r_grant == PORT1))
                          & ~(w_in_resp & (r_grant == PORT0) & req0);
`else
  logic r_rr_last;

  assign w_rr_last = r_rr_last;
  assign w_req0_m  = req0 & ~(w_in_resp & (r_grant == PORT0));
  assign w_req1_m  = req1 & ~(w_in_resp & (r_grant == PORT1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_rr_last <= PORT1;
    end else if (w_in_resp) begin
      r_rr_last <= r_grant;
    end
  end
`endif

  dmem_rr_pick u_pick (
    .i_req0     (w_req0_m),
    .i_req1     (w_req1_m),
    .i_rr_last  (w_rr_last),
    .o_valid_c  (w_pick_valid),
    .o_winner_c (w_pick_id)
  );

  assign w_sel_we    = (w_pick_id == PORT1) ? we1    : we0;
  assign w_sel_addr  = (w_pick_id == PORT1) ? addr1  : addr0;
  assign w_sel_wdata = (w_pick_id == PORT1) ? wdata1 : wdata0;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration happens in IDLE and RESP; ACCESS always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_ACCESS;
          w_load      = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_ACCESS;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered on grant so they are high only during ACCESS; read data lands with ack.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_grant     <= PORT0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      if (w_load) begin
        r_grant     <= w_pick_id;
        r_we        <= w_sel_we;
        r_addr      <= w_sel_addr;
        r_wdata     <= w_sel_wdata;
        r_mem_write <= w_sel_we;
        r_mem_read  <= ~w_sel_we;
      end
      if (r_state == ST_ACCESS) begin
        if (r_grant == PORT0) begin
          r_ack0 <= 1'b1;
          if (!r_we) r_rdata0 <= mem_rdata;
        end else begin
          r_ack1 <= 1'b1;
          if (!r_we) r_rdata1 <= mem_rdata;
        end
      end
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model and per-cycle output check.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Stand-in data memory: async read, write on the clock edge; writes are held off while in reset.
  logic [31:0] bmem [64];
  always @(posedge Clk) if (Rst_n && mem_write) bmem[mem_addr[5:0]] <= mem_wdata;
  assign mem_rdata = bmem[mem_addr[5:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a grant at edge t strobes memory in the following cycle and acks one cycle later.
  bit          m_valid = 1'b0;
  int unsigned t = 0;
  bit          m_has = 1'b0, m_port = 1'b0, m_we = 1'b0, m_rr = 1'b1;
  int unsigned m_edge = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_mem [64];
  bit          e_ack0 = 1'b0, e_ack1 = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata0 = '0, e_rdata1 = '0;

  initial begin : model
    bit arb, ex0, ex1, r0, r1, p;
    forever begin
      @(posedge Clk);
      t++;
      if (!Rst_n) begin
        m_valid = 1'b1; m_has = 1'b0; m_rr = 1'b1;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata0 = '0; e_rdata1 = '0;
      end else begin
        arb = 1'b0; ex0 = 1'b0; ex1 = 1'b0;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        if (m_has && t == m_edge + 1) begin
          if (m_we) m_mem[m_addr[5:0]] = m_wdata;
          else if (m_port) e_rdata1 = m_mem[m_addr[5:0]];
          else e_rdata0 = m_mem[m_addr[5:0]];
          if (m_port) e_ack1 = 1'b1; else e_ack0 = 1'b1;
        end else begin
          if (m_has) begin
            m_rr = m_port; ex0 = !m_port; ex1 = m_port; m_has = 1'b0;
          end
          arb = 1'b1;
        end
        if (arb) begin
          r0 = req0 && !ex0;
          r1 = req1 && !ex1;
          if (r0 || r1) begin
            p       = (r0 && r1) ? !m_rr : r1;
            m_has   = 1'b1;
            m_edge  = t;
            m_port  = p;
            m_we    = p ? we1 : we0;
            m_addr  = p ? addr1 : addr0;
            m_wdata = p ? wdata1 : wdata0;
            e_addr  = m_addr;
            e_wdata = m_wdata;
            e_wr    = m_we;
            e_rd    = !m_we;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge Clk);
      if (m_valid) begin
        chk("cyc_ack0",      32'(ack0),      32'(e_ack0));
        chk("cyc_ack1",      32'(ack1),      32'(e_ack1));
        chk("cyc_mem_read",  32'(mem_read),  32'(e_rd));
        chk("cyc_mem_write", 32'(mem_write), 32'(e_wr));
        chk("cyc_mem_addr",  mem_addr,  e_addr);
        chk("cyc_mem_wdata", mem_wdata, e_wdata);
        chk("cyc_rdata0",    rdata0,    e_rdata0);
        chk("cyc_rdata1",    rdata1,    e_rdata1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    int ack_seq[$];
    int n_ack1;
    Rst_n = 1'b0; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 0);
    chk("rst_mem_addr", mem_addr, 0);
    Rst_n = 1'b1;

    // Single write from port 0
    @(negedge Clk); req0 = 1'b1; we0 = 1'b1; addr0 = 32'd50; wdata0 = 32'd1200;
    @(negedge Clk);
    chk("wr_mem_write", 32'(mem_write), 1);
    chk("wr_mem_read", 32'(mem_read), 0);
    chk("wr_mem_addr", mem_addr, 50);
    chk("wr_mem_wdata", mem_wdata, 1200);
    chk("wr_no_ack_yet", 32'(ack0), 0);
    @(negedge Clk);
    chk("wr_ack0", 32'(ack0), 1);
    chk("wr_ack1", 32'(ack1), 0);
    chk("wr_strobes_off", 32'({mem_read, mem_write}), 0);
    req0 = 1'b0;
    @(negedge Clk);
    chk("wr_ack0_pulse", 32'(ack0), 0);

    // Read back from port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd50; wdata0 = '0;
    @(negedge Clk);
    chk("rd_mem_read", 32'(mem_read), 1);
    chk("rd_mem_write", 32'(mem_write), 0);
    @(negedge Clk);
    chk("rd_ack0", 32'(ack0), 1);
    chk("rd_rdata0", rdata0, 1200);
    chk("rd_rdata1", rdata1, 0);
    req0 = 1'b0;
    @(negedge Clk);
    chk("rd_mem_read_off", 32'(mem_read), 0);

    // Simultaneous writes right after reset: port 0 first, port 1 with no idle gap
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd63; wdata0 = 32'd5400;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd40; wdata1 = 32'd400;
    @(negedge Clk);
    chk("tie_c1_addr", mem_addr, 63);
    chk("tie_c1_write", 32'(mem_write), 1);
    @(negedge Clk);
    chk("tie_c2_ack0", 32'(ack0), 1);
    chk("tie_c2_ack1", 32'(ack1), 0);
    req0 = 1'b0;
    @(negedge Clk);
    chk("tie_c3_write", 32'(mem_write), 1);
    chk("tie_c3_addr", mem_addr, 40);
    chk("tie_c3_wdata", mem_wdata, 400);
    chk("tie_c3_ack0", 32'(ack0), 0);
    @(negedge Clk);
    chk("tie_c4_ack1", 32'(ack1), 1);
    req1 = 1'b0;

    // Continuous contention: reads from both ports for 8 cycles
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd50;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd63;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (ack0) begin
        ack_seq.push_back(0);
        chk("cont_rdata0", rdata0, 1200);
      end
      if (ack1) begin
        ack_seq.push_back(1);
        chk("cont_rdata1", rdata1, 5400);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_ack_count", 32'(ack_seq.size()), 4);
    for (int i = 0; i < ack_seq.size(); i++) chk("cont_ack_order", 32'(ack_seq[i]), 32'(i % 2));

    // Reset during ACCESS of a write to addr 40
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd40; wdata0 = 32'd9999;
    @(negedge Clk);
    chk("rstmid_access", 32'(mem_write), 1);
    Rst_n = 1'b0; req0 = 1'b0;
    @(negedge Clk);
    chk("rstmid_strobes", 32'({mem_read, mem_write}), 0);
    chk("rstmid_ack0", 32'(ack0), 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rstmid_no_ack0", 32'(ack0), 0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd40;
    @(negedge Clk);
    chk("rstmid_rd_read", 32'(mem_read), 1);
    @(negedge Clk);
    chk("rstmid_rd_ack1", 32'(ack1), 1);
    chk("rstmid_rd_rdata1", rdata1, 400);
    req1 = 1'b0;
    @(negedge Clk);

    // Port 1 drops its request during ACCESS
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd63;
    @(negedge Clk);
    chk("drop_access", 32'(mem_read), 1);
    req1 = 1'b0;
    n_ack1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (ack1) begin
        n_ack1++;
        chk("drop_rdata1", rdata1, 5400);
      end
      if (i > 0) chk("drop_no_second", 32'({mem_read, mem_write}), 0);
    end
    chk("drop_ack1_count", 32'(n_ack1), 1);

    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
